// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   XLEN_DEFAULT  default address/PC width
//   INSTR_W       instruction word width
//   fetch_entry_t {pc, instr} pair handed to IF/ID
//   NOP_INSTR     canonical NOP (addi x0,x0,0) for the downstream flush path
package if_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W      = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// Bus bundle of the fetch stage: imem request/response, EX redirect, IF/ID output.
//   master : fetch unit side (drives imem request and IF/ID output)
//   slave  : environment side (memory, EX, IF/ID register)
interface if_fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_unit_fifo.sv
// Generic synchronous FIFO, power-of-2 DEPTH.
//   CK/RESET      clock, synchronous active-high reset
//   push/din      write (accepted when not full, or full with a pop)
//   pop/dout      read; dout is the head, valid while !empty
//   flush         empties the FIFO, wins over push/pop
//   count/full/empty occupancy
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   CK,
  input  logic                   RESET,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CK) begin
    if (RESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CK) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC generation, imem request issue, in-order response
// pairing, instruction buffering toward IF/ID, and EX redirect with flush of
// in-flight fetches.
//   CK/RESET  clock, synchronous active-high reset
//   bus       if_fetch_unit_if.master (imem req/rsp, redirect, IF/ID output)
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic              CK,
  input logic              RESET,
  if_fetch_unit_if.master  bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = XLEN + INSTR_W;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding, drop;
  logic [CW-1:0]   pcq_count, buf_count;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] pcq_head;
  logic [BW-1:0]   buf_head;
  logic            pcq_full, pcq_empty, buf_full, buf_empty;
  logic            redirect, req_valid, req_fire;
  logic            rsp_ok, rsp_keep, rsp_drop, id_valid, id_pop;
  logic            unused_ok;

  assign redirect = bus.redirect_valid;

  // Credit: every request already holds a buffer slot, so responses never stall.
  assign credit_used = {1'b0, outstanding} + {1'b0, buf_count};
  assign req_valid   = !RESET && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign req_fire    = req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;

  // A response with nothing outstanding is illegal; ignore it rather than underflow.
  assign rsp_ok   = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_ok && (drop == '0);
  assign rsp_drop = rsp_ok && (drop != '0);

  assign id_valid     = !buf_empty;
  assign id_pop       = id_valid && bus.id_ready && !redirect;
  assign bus.id_valid = id_valid;
  assign bus.id_pc    = id_valid ? buf_head[BW-1:INSTR_W] : '0;
  assign bus.id_instr = id_valid ? buf_head[INSTR_W-1:0]  : '0;

  always_ff @(posedge CK) begin
    if (RESET) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
      if (redirect) begin
        pc   <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        // No request fires in a redirect cycle, so everything still in flight
        // after this cycle's response belongs to the old path.
        drop <= outstanding - CW'(rsp_ok);
      end else begin
        if (req_fire) pc   <= pc + XLEN'(4);
        if (rsp_drop) drop <= drop - CW'(1);
      end
    end
  end

  // PCs of live requests; dropped responses were already flushed from here.
  if_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pcq (
    .CK(CK), .RESET(RESET),
    .push(req_fire), .pop(rsp_keep), .flush(redirect),
    .din(pc), .dout(pcq_head),
    .count(pcq_count), .full(pcq_full), .empty(pcq_empty)
  );

  if_fifo #(.DEPTH(DEPTH), .WIDTH(BW)) u_ibuf (
    .CK(CK), .RESET(RESET),
    .push(rsp_keep), .pop(id_pop), .flush(redirect),
    .din({pcq_head, bus.imem_rsp_data}), .dout(buf_head),
    .count(buf_count), .full(buf_full), .empty(buf_empty)
  );

  assign unused_ok = ^{pcq_count, pcq_full, pcq_empty, buf_full, bus.redirect_pc[1:0]};

  rsp_legal: assert property (@(posedge CK) disable iff (RESET)
    bus.imem_rsp_valid |-> (outstanding != '0));
endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic CK = 1'b0;
  logic RESET;
  always #5 CK = ~CK;

  if_fetch_unit_if #(.XLEN(XLEN)) bus();

  if_fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .CK(CK), .RESET(RESET), .bus(bus)
  );

  // Reference: memory+in-flight list (with a stale mark set by redirects), and
  // the decode-side queue of {pc, instr}.
  typedef struct { logic [31:0] addr; bit stale; int due; } flight_t;
  flight_t      infl[$];
  fetch_entry_t bq[$];
  logic [31:0]  m_pc;
  int cyc, lat_lo, lat_hi;
  int checks, errors;

  logic [31:0] fire_log[$], id_log[$], id_ilog[$];
  int          fire_cyc[$];
  int          first_idv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    fire_log.delete(); fire_cyc.delete(); id_log.delete(); id_ilog.delete();
    first_idv = -1;
  endtask

  // One clock cycle: drive at negedge, compare against the model, advance the model.
  task automatic step(input bit rst, input bit rv, input logic [31:0] rpc,
                      input bit rdy, input bit idr);
    bit          rsp, e_rv, e_idv, fire, pop;
    logic [31:0] e_pc, e_in;
    flight_t     f;
    @(negedge CK);
    RESET                  = rst;
    bus.redirect_valid     = rv;
    bus.redirect_pc        = rpc;
    bus.imem_req_ready     = rdy;
    bus.id_ready           = idr;
    rsp                    = !rst && (infl.size() > 0) && (infl[0].due <= cyc);
    bus.imem_rsp_valid     = rsp;
    bus.imem_rsp_data      = rsp ? mem_word(infl[0].addr) : $urandom;
    #1;
    if (rst) begin
      chk("req_valid_in_reset", {31'b0, bus.imem_req_valid}, 32'd0);
      infl.delete(); bq.delete(); m_pc = RST_PC;
    end else begin
      e_rv  = !rv && (infl.size() + bq.size() < DEPTH);
      e_idv = (bq.size() != 0);
      e_pc  = e_idv ? bq[0].pc    : 32'd0;
      e_in  = e_idv ? bq[0].instr : 32'd0;
      chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, e_rv});
      if (e_rv) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("id_valid", {31'b0, bus.id_valid}, {31'b0, e_idv});
      chk("id_pc", bus.id_pc, e_pc);
      chk("id_instr", bus.id_instr, e_in);

      if (bus.imem_req_valid === 1'b1 && rdy) begin
        fire_log.push_back(bus.imem_req_addr); fire_cyc.push_back(cyc);
      end
      if (bus.id_valid === 1'b1 && idr && !rv) begin
        id_log.push_back(bus.id_pc); id_ilog.push_back(bus.id_instr);
      end
      if (first_idv < 0 && bus.id_valid === 1'b1) first_idv = cyc;

      fire = e_rv && rdy;
      pop  = e_idv && idr && !rv;
      if (pop) void'(bq.pop_front());
      if (rsp) begin
        f = infl.pop_front();
        if (!f.stale && !rv) bq.push_back('{pc: f.addr, instr: mem_word(f.addr)});
      end
      if (fire) begin
        infl.push_back('{addr: m_pc, stale: 1'b0, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
        m_pc = m_pc + 32'd4;
      end
      if (rv) begin
        m_pc = rpc & ~32'h3;
        bq.delete();
        foreach (infl[i]) infl[i].stale = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input bit rdy, input bit idr);
    for (int i = 0; i < n; i++) step(0, 0, 32'd0, rdy, idr);
  endtask

  task automatic do_reset();
    step(1, 0, 32'd0, 0, 0);
    step(1, 0, 32'd0, 0, 0);
  endtask

  int hits;
  bit r_rst, r_rv, r_rdy, r_idr;

  initial begin
    checks = 0; errors = 0; cyc = 0; lat_lo = 1; lat_hi = 1;
    RESET = 1'b1;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.id_ready = 0;
    clear_logs();

    // Reset state and wrap from RESET_PC, 1-cycle memory.
    do_reset();
    clear_logs();
    step(0, 0, 32'd0, 1, 1);
    chk("rst_id_valid", {31'b0, bus.id_valid}, 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'd0);
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("rst_req_addr", bus.imem_req_addr, 32'hFFFF_FFF8);
    run(8, 1, 1);
    chk("wrap_fire_n", 32'(fire_log.size() >= 3), 32'd1);
    chk("wrap_fire0", fire_log[0], 32'hFFFF_FFF8);
    chk("wrap_fire1", fire_log[1], 32'hFFFF_FFFC);
    chk("wrap_fire2", fire_log[2], 32'h0000_0000);
    chk("first_id_latency", 32'(first_idv - fire_cyc[0]), 32'd2);
    chk("wrap_id0", id_log[0], 32'hFFFF_FFF8);
    chk("wrap_id1", id_log[1], 32'hFFFF_FFFC);
    chk("wrap_id2", id_log[2], 32'h0000_0000);
    chk("wrap_instr0", id_ilog[0], mem_word(32'hFFFF_FFF8));

    // Decode stalled: exactly two buffered, fetch stops, then resumes at 0x8.
    do_reset();
    step(0, 1, 32'd0, 1, 1);
    clear_logs();
    run(10, 1, 0);
    chk("stall_fires", 32'(fire_log.size()), 32'd2);
    chk("stall_f0", fire_log[0], 32'h0);
    chk("stall_f1", fire_log[1], 32'h4);
    chk("stall_idv", {31'b0, bus.id_valid}, 32'd1);
    chk("stall_idpc", bus.id_pc, 32'h0);
    chk("stall_reqv", {31'b0, bus.imem_req_valid}, 32'd0);
    clear_logs();
    run(10, 1, 1);
    chk("resume_f0", fire_log[0], 32'h8);
    chk("resume_id0", id_log[0], 32'h0);
    chk("resume_id1", id_log[1], 32'h4);
    chk("resume_id2", id_log[2], 32'h8);
    chk("resume_id3", id_log[3], 32'hC);

    // Memory not ready: address held at 0x4.
    do_reset();
    step(0, 1, 32'd0, 1, 1);
    step(0, 0, 32'd0, 1, 1);
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 32'd0, 0, 1);
      chk("hold_addr", bus.imem_req_addr, 32'h4);
    end
    chk("hold_nofire", 32'(fire_log.size()), 32'd0);
    run(4, 1, 1);
    chk("hold_next", fire_log[0], 32'h4);

    // Redirect to 0x103 with 0x8 and 0xC in flight.
    do_reset();
    lat_lo = 4; lat_hi = 4;
    step(0, 1, 32'h8, 1, 1);
    clear_logs();
    run(3, 1, 1);
    chk("inflight_f0", fire_log[0], 32'h8);
    chk("inflight_f1", fire_log[1], 32'hC);
    lat_lo = 1; lat_hi = 1;
    clear_logs();
    step(0, 1, 32'h103, 1, 1);
    run(12, 1, 1);
    chk("redir_fire0", fire_log[0], 32'h100);
    chk("redir_id0", id_log[0], 32'h100);
    hits = 0;
    foreach (id_log[i]) if (id_log[i] == 32'h8 || id_log[i] == 32'hC) hits++;
    chk("redir_no_stale", 32'(hits), 32'd0);

    // Back-to-back redirects: only 0x300 is fetched.
    do_reset();
    lat_lo = 2; lat_hi = 2;
    step(0, 1, 32'h0, 1, 1);
    run(2, 1, 1);
    clear_logs();
    step(0, 1, 32'h200, 1, 1);
    step(0, 1, 32'h300, 1, 1);
    lat_lo = 1; lat_hi = 1;
    run(12, 1, 1);
    chk("b2b_fire0", fire_log[0], 32'h300);
    chk("b2b_id0", id_log[0], 32'h300);
    hits = 0;
    foreach (id_log[i]) if (id_log[i] >= 32'h200 && id_log[i] < 32'h300) hits++;
    foreach (fire_log[i]) if (fire_log[i] >= 32'h200 && fire_log[i] < 32'h300) hits++;
    chk("b2b_no_200", 32'(hits), 32'd0);

    // Randomized traffic with variable latency, redirects and mid-stream resets.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(999) < 3) || (i == 1500);
      r_rv  = ($urandom_range(99) < 5);
      r_rdy = ($urandom_range(99) < 70);
      r_idr = ($urandom_range(99) < 60);
      if (r_rst) begin
        step(1, 0, 32'd0, r_rdy, r_idr);
        step(0, 0, 32'd0, r_rdy, r_idr);
        chk("midrst_id_valid", {31'b0, bus.id_valid}, 32'd0);
        chk("midrst_addr", bus.imem_req_addr, RST_PC);
      end else begin
        step(0, r_rv, $urandom, r_rdy, r_idr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
